// File: rtl/lcd_readback_if.sv
// Host-side handshake for the LCD display-RAM readback block.
// The game logic drives the request side; the readback block returns the byte.
interface lcd_readback_if;
  logic       req;
  logic [2:0] page;
  logic [6:0] col;
  logic       rdy;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       err;

  modport master (
    output req, page, col,
    input  rdy, rd_data, rd_valid, err
  );

  modport slave (
    input  req, page, col,
    output rdy, rd_data, rd_valid, err
  );
endinterface

// File: rtl/lcd_readback.sv
// Reads one display-RAM byte back from a dual-controller (CS1/CS2) 128x64
// KS0108-style panel. Sequence per request: for each of SET_PAGE, SET_COL,
// DUMMY_READ and DATA_READ, poll the busy flag until clear, then perform the
// access. Every bus output is a flop, so E is a clean registered strobe.
module lcd_readback #(
  parameter int unsigned POLL_MAX = 255  // busy polls allowed per op, 1..255
) (
  input  logic       LCD_CLK,
  input  logic       RESET,
  lcd_readback_if.slave host,
  input  logic [7:0] LCD_DATA_IN,
  output logic [7:0] LCD_DATA_OUT,
  output logic       LCD_DATA_OE,
  output logic       LCD_ENABLE,
  output logic       LCD_RW,
  output logic       LCD_DI,
  output logic       LCD_CS1,
  output logic       LCD_CS2
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    E_HI1 = 3'd2,
    E_HI2 = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_SET_PAGE   = 2'd0,
    OP_SET_COL    = 2'd1,
    OP_DUMMY_READ = 2'd2,
    OP_DATA_READ  = 2'd3
  } op_t;

  typedef enum logic {
    PH_POLL   = 1'b0,
    PH_ACCESS = 1'b1
  } phase_t;

  localparam logic [7:0] POLL_LIMIT = 8'(POLL_MAX);

  // Sequencer context
  state_t     state_q,    state_d;
  op_t        op_q,       op_d;
  phase_t     phase_q,    phase_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic [2:0] page_q,     page_d;
  logic [6:0] col_q,      col_d;
  logic       busy_q,     busy_d;

  // Registered outputs
  logic       rdy_q,      rdy_d;
  logic [7:0] rd_data_q,  rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       err_q,      err_d;
  logic       e_q,        e_d;
  logic       rw_q,       rw_d;
  logic       di_q,       di_d;
  logic       cs1_q,      cs1_d;
  logic       cs2_q,      cs2_d;
  logic       oe_q,       oe_d;
  logic [7:0] dout_q,     dout_d;

  // Next-state logic: walks poll/access phases of the four ops.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    phase_d    = phase_q;
    poll_cnt_d = poll_cnt_q;
    page_d     = page_q;
    col_d      = col_q;
    busy_d     = busy_q;
    rd_data_d  = rd_data_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (host.req) begin
          page_d     = host.page;
          col_d      = host.col;
          op_d       = OP_SET_PAGE;
          phase_d    = PH_POLL;
          poll_cnt_d = 8'd0;
          state_d    = SETUP;
        end
      end

      SETUP: state_d = E_HI1;

      E_HI1: state_d = E_HI2;

      E_HI2: begin
        // Read data is taken at the edge that ends the E-high window.
        if (phase_q == PH_POLL) begin
          busy_d  = LCD_DATA_IN[7];
          state_d = CHECK;
        end else if (op_q == OP_DATA_READ) begin
          rd_data_d = LCD_DATA_IN;
          state_d   = DONE;
        end else begin
          op_d       = op_t'(op_q + 2'd1);
          phase_d    = PH_POLL;
          poll_cnt_d = 8'd0;
          state_d    = SETUP;
        end
      end

      CHECK: begin
        if (!busy_q) begin
          phase_d = PH_ACCESS;
          state_d = SETUP;
        end else begin
          poll_cnt_d = poll_cnt_q + 8'd1;
          if (poll_cnt_d == POLL_LIMIT) begin
            // Panel never came ready: abort, leave rd_data untouched.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the output flops line up with state.
  always_comb begin
    rdy_d      = 1'b0;
    rd_valid_d = 1'b0;
    e_d        = 1'b0;
    rw_d       = 1'b1;
    di_d       = 1'b0;
    cs1_d      = 1'b0;
    cs2_d      = 1'b0;
    oe_d       = 1'b0;
    dout_d     = 8'h00;

    case (state_d)
      IDLE: rdy_d = 1'b1;

      DONE: rd_valid_d = 1'b1;

      SETUP, E_HI1, E_HI2, CHECK: begin
        // Control lines hold through SETUP, both E-high cycles and CHECK.
        cs1_d = ~col_d[6];
        cs2_d =  col_d[6];
        e_d   = (state_d == E_HI1) || (state_d == E_HI2);
        if (phase_d == PH_POLL) begin
          rw_d = 1'b1;
          di_d = 1'b0;
        end else begin
          case (op_d)
            OP_SET_PAGE: begin
              rw_d   = 1'b0;
              oe_d   = 1'b1;
              dout_d = {5'b10111, page_d};
            end
            OP_SET_COL: begin
              rw_d   = 1'b0;
              oe_d   = 1'b1;
              dout_d = {2'b01, col_d[5:0]};
            end
            default: begin
              // Dummy and data reads: bus released, data register selected.
              rw_d = 1'b1;
              di_d = 1'b1;
            end
          endcase
        end
      end

      default: rdy_d = 1'b0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge LCD_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (RESET) begin
      state_q    <= IDLE;
      op_q       <= OP_SET_PAGE;
      phase_q    <= PH_POLL;
      poll_cnt_q <= 8'd0;
      page_q     <= 3'd0;
      col_q      <= 7'd0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b1;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      e_q        <= 1'b0;
      rw_q       <= 1'b1;
      di_q       <= 1'b0;
      cs1_q      <= 1'b0;
      cs2_q      <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      phase_q    <= phase_d;
      poll_cnt_q <= poll_cnt_d;
      page_q     <= page_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      e_q        <= e_d;
      rw_q       <= rw_d;
      di_q       <= di_d;
      cs1_q      <= cs1_d;
      cs2_q      <= cs2_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
    end
  end

  assign host.rdy      = rdy_q;
  assign host.rd_data  = rd_data_q;
  assign host.rd_valid = rd_valid_q;
  assign host.err      = err_q;

  assign LCD_ENABLE   = e_q;
  assign LCD_RW       = rw_q;
  assign LCD_DI       = di_q;
  assign LCD_CS1      = cs1_q;
  assign LCD_CS2      = cs2_q;
  assign LCD_DATA_OE  = oe_q;
  assign LCD_DATA_OUT = dout_q;

endmodule
